axi_lite_access_arbiter: RTL and testbench
==========================================

AXI_LITE_ACCESS_ARBITER -- requirements
Module: axi_lite_access_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 2, number of requesters (2..4).
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, AXI address width.
REQ-003 SHALL have parameter DATA_WIDTH, default 32, AXI data width.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 1000, per-transaction AXI timeout in clocks.
REQ-005 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-007 SHALL have port req  input  NUM_REQ  per-requester access request.
REQ-008 SHALL have port we  input  NUM_REQ  per-requester write(1)/read(0).
REQ-009 SHALL have port addr  input  NUM_REQ x ADDR_WIDTH  per-requester byte address.
REQ-010 SHALL have port wdata  input  NUM_REQ x DATA_WIDTH  per-requester write data.
REQ-011 SHALL have port wstrb  input  NUM_REQ x DATA_WIDTH/8  per-requester byte strobes.
REQ-012 SHALL have port ack  output  NUM_REQ  one-cycle completion pulse to granted requester.
REQ-013 SHALL have port rdata  output  DATA_WIDTH  read data, valid with ack.
REQ-014 SHALL have port resp  output  2  AXI response code, valid with ack.
REQ-015 SHALL have port timeout  output  1  one-cycle pulse on transaction timeout.
REQ-016 SHALL have port busy  output  1  high when FSM not in IDLE.
REQ-017 SHALL have port grant_id  output  2  index of current/last granted requester.
REQ-018 SHALL have port axi  axi4_lite_if.master  -  AXI4-Lite master toward Register_Block.

Function
REQ-019 Requester rule: req and we/addr/wdata/wstrb held stable until ack; req high in cycle after ack = new request.
REQ-020 FSM states: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, DONE.
REQ-021 IDLE: any req high -> grant one requester, register its fields, go WR_REQ (we=1) or RD_REQ (we=0) next cycle.
REQ-022 Arbitration round-robin: search starts at index after last grant; after reset, search starts at 0.
REQ-023 WR_REQ: awvalid and wvalid asserted together; each deasserted independently on its own handshake; both done -> WR_RESP.
REQ-024 WR_RESP: bready=1; bvalid -> capture bresp, go DONE.
REQ-025 RD_REQ: arvalid=1 until arready -> RD_RESP; RD_RESP: rready=1; rvalid -> capture rdata/rresp, go DONE.
REQ-026 DONE: ack[grant_id]=1 for exactly one cycle, rdata/resp held until next DONE, then IDLE.
REQ-027 Write ack: rdata unchanged from previous value; resp=bresp.
REQ-028 axprot driven 3'b000; awaddr/araddr = registered addr; wstrb = registered wstrb.
REQ-029 Timeout counter cleared on grant, increments each cycle in WR_*/RD_* states; reaching TIMEOUT_CYCLES -> deassert all valids, timeout pulse, resp=2'b10, go DONE.
REQ-030 IDLE: bready=rready=1; stray late B/R beats accepted and discarded, not forwarded.
REQ-031 Best-case latency (slave ready same cycle, response next cycle): req at cycle 0 -> ack at cycle 3.
REQ-032 New req arriving while busy is not granted until FSM returns to IDLE; no preemption.
REQ-033 Simultaneous req from all requesters: exactly one grant per IDLE cycle, per REQ-022.

Reset
REQ-034 rst_n low: state=IDLE, all valids=0, bready=rready=0, ack=0, rdata=0, resp=2'b00, timeout=0, busy=0, grant_id=0, RR pointer=0, timeout counter=0.
REQ-035 Reset mid-transaction abandons it without ack; first post-reset cycle, bready/rready rise per REQ-030.

Structure
REQ-036 Package axiuart_arb_pkg SHALL hold FSM state enum, AXI resp constants (OKAY=2'b00, SLVERR=2'b10), TIMEOUT default.
REQ-037 Sub-module rr_arbiter (combinational pick + registered pointer) SHALL implement REQ-022.

Verification
REQ-038 Single write req[0], addr 0x1004, wdata 0xA5A5_5A5A, zero-wait slave -> AW/W at cycle 1, ack[0] at cycle 3, resp 2'b00.
REQ-039 req[0] and req[1] both high continuously for 4 transactions -> grants 0,1,0,1.
REQ-040 Read 0x1000, slave returns 0x0000_0001 with 5-cycle rvalid delay -> ack with rdata 0x0000_0001, resp 2'b00.
REQ-041 Slave never asserts awready, TIMEOUT_CYCLES=16 -> timeout pulse and ack, resp 2'b10, 16 cycles after grant.
REQ-042 awready 2 cycles before wready -> awvalid drops first, wvalid held until its handshake, single B accepted.
REQ-043 rst_n pulsed low during RD_RESP -> no ack, all outputs at REQ-034 values, next req serviced normally.

Source files
------------

// File: rtl/axiuart_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module  : axiuart_arb_pkg
// Brief   : Shared FSM state encoding, AXI response codes and helpers for the
//           AXI-Lite access arbiter.
// Revision: 1.0 - initial release
// ============================================================================
package axiuart_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_REQ  = 3'd1,
        ST_WR_RESP = 3'd2,
        ST_RD_REQ  = 3'd3,
        ST_RD_RESP = 3'd4,
        ST_DONE    = 3'd5
    } arb_state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int TIMEOUT_DEFAULT = 1000;

    // Distance of requester idx from the round-robin start point ptr (0 = first choice).
    function automatic int rr_distance(input int idx, input int ptr, input int n);
        return (idx - ptr + n) % n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/axi4_lite_if.sv
`default_nettype none
// ============================================================================
// Module  : axi4_lite_if
// Brief   : AXI4-Lite bundle with master and slave views.
// Revision: 1.0 - initial release
// ============================================================================
interface axi4_lite_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                    awvalid;
    logic                    awready;
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [2:0]              awprot;
    logic                    wvalid;
    logic                    wready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    bvalid;
    logic                    bready;
    logic [1:0]              bresp;
    logic                    arvalid;
    logic                    arready;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic [2:0]              arprot;
    logic                    rvalid;
    logic                    rready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;

    modport master (
        output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
               arvalid, araddr, arprot, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

    modport slave (
        input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
               arvalid, araddr, arprot, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
endinterface
`default_nettype wire

// File: rtl/axi_lite_access_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : rr_arbiter
// Brief   : Round-robin pick over NUM_REQ requesters with a registered
//           start pointer that moves past each accepted grant.
// Revision: 1.0 - initial release
// ============================================================================
module rr_arbiter
    import axiuart_arb_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic               advance,
    output logic               gnt_valid,
    output logic [1:0]         gnt_idx
);

    logic [1:0] ptr_q;
    logic [1:0] ptr_d;
    int         best_dist;

    // Closest active requester at or after the pointer wins.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = 2'd0;
        best_dist = NUM_REQ;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (req[j] && (rr_distance(j, int'(ptr_q), NUM_REQ) < best_dist)) begin
                best_dist = rr_distance(j, int'(ptr_q), NUM_REQ);
                gnt_valid = 1'b1;
                gnt_idx   = 2'(j);
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (advance && gnt_valid) begin
            ptr_d = (int'(gnt_idx) == NUM_REQ - 1) ? 2'd0 : gnt_idx + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= 2'd0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/axi_lite_access_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : axi_lite_access_arbiter
// Brief   : Shares one AXI4-Lite master port among NUM_REQ simple requesters,
//           one transaction at a time, with round-robin grant and timeout.
// Revision: 1.0 - initial release
// ============================================================================
module axi_lite_access_arbiter
    import axiuart_arb_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_REQ-1:0]              req,
    input  logic [NUM_REQ-1:0]              we,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]   addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   wdata,
    input  logic [NUM_REQ*DATA_WIDTH/8-1:0] wstrb,
    output logic [NUM_REQ-1:0]              ack,
    output logic [DATA_WIDTH-1:0]           rdata,
    output logic [1:0]                      resp,
    output logic                            timeout,
    output logic                            busy,
    output logic [1:0]                      grant_id,
    axi4_lite_if.master                     axi
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    // One spare bit so the count can pass the limit without wrapping.
    localparam int CNT_WIDTH  = $clog2(TIMEOUT_CYCLES) + 1;

    arb_state_e            state_q, state_d;
    logic                  aw_pend_q, aw_pend_d;
    logic                  w_pend_q, w_pend_d;
    logic                  ar_pend_q, ar_pend_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [STRB_WIDTH-1:0] wstrb_q, wstrb_d;
    logic [1:0]            grant_id_q, grant_id_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [1:0]            resp_q, resp_d;
    logic                  timeout_q, timeout_d;
    logic [CNT_WIDTH-1:0]  tcnt_q, tcnt_d;

    logic                  gnt_valid;
    logic [1:0]            gnt_idx;
    logic                  arb_advance;
    logic                  sel_we;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic [STRB_WIDTH-1:0] sel_wstrb;
    logic [CNT_WIDTH-1:0]  tcnt_inc;
    logic                  in_txn;
    logic                  tmo_hit;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .advance   (arb_advance),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx)
    );

    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        sel_wstrb = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_idx == 2'(i)) begin
                sel_we    = we[i];
                sel_addr  = addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_wdata = wdata[i*DATA_WIDTH +: DATA_WIDTH];
                sel_wstrb = wstrb[i*STRB_WIDTH +: STRB_WIDTH];
            end
        end
    end

    assign in_txn   = (state_q == ST_WR_REQ) || (state_q == ST_WR_RESP) ||
                      (state_q == ST_RD_REQ) || (state_q == ST_RD_RESP);
    assign tcnt_inc = tcnt_q + 1'b1;
    assign tmo_hit  = in_txn && (tcnt_inc >= CNT_WIDTH'(TIMEOUT_CYCLES));

    always_comb begin
        state_d     = state_q;
        aw_pend_d   = aw_pend_q;
        w_pend_d    = w_pend_q;
        ar_pend_d   = ar_pend_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        grant_id_d  = grant_id_q;
        rdata_d     = rdata_q;
        resp_d      = resp_q;
        timeout_d   = 1'b0;
        tcnt_d      = in_txn ? tcnt_inc : tcnt_q;
        arb_advance = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (gnt_valid) begin
                    arb_advance = 1'b1;
                    grant_id_d  = gnt_idx;
                    addr_d      = sel_addr;
                    wdata_d     = sel_wdata;
                    wstrb_d     = sel_wstrb;
                    tcnt_d      = '0;
                    if (sel_we) begin
                        state_d   = ST_WR_REQ;
                        aw_pend_d = 1'b1;
                        w_pend_d  = 1'b1;
                    end else begin
                        state_d   = ST_RD_REQ;
                        ar_pend_d = 1'b1;
                    end
                end
            end
            ST_WR_REQ: begin
                aw_pend_d = aw_pend_q & ~axi.awready;
                w_pend_d  = w_pend_q & ~axi.wready;
                if (!aw_pend_d && !w_pend_d) begin
                    state_d = ST_WR_RESP;
                end
            end
            ST_WR_RESP: begin
                if (axi.bvalid) begin
                    resp_d  = axi.bresp;
                    state_d = ST_DONE;
                end
            end
            ST_RD_REQ: begin
                if (axi.arready) begin
                    ar_pend_d = 1'b0;
                    state_d   = ST_RD_RESP;
                end
            end
            ST_RD_RESP: begin
                if (axi.rvalid) begin
                    rdata_d = axi.rdata;
                    resp_d  = axi.rresp;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A response landing on the limit cycle still wins over the timeout.
        if (tmo_hit && (state_d == state_q)) begin
            state_d   = ST_DONE;
            aw_pend_d = 1'b0;
            w_pend_d  = 1'b0;
            ar_pend_d = 1'b0;
            resp_d    = RESP_SLVERR;
            timeout_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            aw_pend_q  <= 1'b0;
            w_pend_q   <= 1'b0;
            ar_pend_q  <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            grant_id_q <= 2'd0;
            rdata_q    <= '0;
            resp_q     <= RESP_OKAY;
            timeout_q  <= 1'b0;
            tcnt_q     <= '0;
        end else begin
            state_q    <= state_d;
            aw_pend_q  <= aw_pend_d;
            w_pend_q   <= w_pend_d;
            ar_pend_q  <= ar_pend_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            grant_id_q <= grant_id_d;
            rdata_q    <= rdata_d;
            resp_q     <= resp_d;
            timeout_q  <= timeout_d;
            tcnt_q     <= tcnt_d;
        end
    end

    always_comb begin
        ack = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            ack[i] = (state_q == ST_DONE) && (grant_id_q == 2'(i));
        end
    end

    assign rdata    = rdata_q;
    assign resp     = resp_q;
    assign timeout  = timeout_q;
    assign busy     = (state_q != ST_IDLE);
    assign grant_id = grant_id_q;

    assign axi.awvalid = aw_pend_q;
    assign axi.awaddr  = addr_q;
    assign axi.awprot  = 3'b000;
    assign axi.wvalid  = w_pend_q;
    assign axi.wdata   = wdata_q;
    assign axi.wstrb   = wstrb_q;
    assign axi.arvalid = ar_pend_q;
    assign axi.araddr  = addr_q;
    assign axi.arprot  = 3'b000;
    // Idle drains stray late beats; gating with rst_n keeps them low in reset.
    assign axi.bready  = (state_q == ST_WR_RESP) || ((state_q == ST_IDLE) && rst_n);
    assign axi.rready  = (state_q == ST_RD_RESP) || ((state_q == ST_IDLE) && rst_n);

endmodule
`default_nettype wire

// File: tb/tb_axi_lite_access_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_axi_lite_access_arbiter
// Brief   : Directed self-checking bench for axi_lite_access_arbiter with a
//           small configurable AXI4-Lite slave model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_axi_lite_access_arbiter;

    localparam int NR = 3;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [NR-1:0]   req = '0;
    logic [NR-1:0]   we = '0;
    logic [NR*32-1:0] addr = '0;
    logic [NR*32-1:0] wdata = '0;
    logic [NR*4-1:0] wstrb = '0;
    logic [NR-1:0]   ack;
    logic [31:0]     rdata;
    logic [1:0]      resp;
    logic            timeout;
    logic            busy;
    logic [1:0]      grant_id;

    int n_total = 0;
    int n_bad   = 0;

    axi4_lite_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) axi_bus ();

    axi_lite_access_arbiter #(
        .NUM_REQ        (NR),
        .ADDR_WIDTH     (32),
        .DATA_WIDTH     (32),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .we       (we),
        .addr     (addr),
        .wdata    (wdata),
        .wstrb    (wstrb),
        .ack      (ack),
        .rdata    (rdata),
        .resp     (resp),
        .timeout  (timeout),
        .busy     (busy),
        .grant_id (grant_id),
        .axi      (axi_bus.master)
    );

    always #5 clk = ~clk;

    // Slave model: ready after a per-channel wait, B one cycle after the last
    // write handshake, R s_r_dly cycles later than the zero-wait case.
    logic        s_aw_en = 1'b1, s_w_en = 1'b1;
    int          s_aw_dly = 0, s_w_dly = 0, s_r_dly = 0;
    int          s_aw_cnt = 0, s_w_cnt = 0, s_r_cnt = 0;
    logic        s_aw_seen = 1'b0, s_w_seen = 1'b0, s_r_pend = 1'b0;
    logic        s_bvalid = 1'b0, s_rvalid = 1'b0;
    logic [1:0]  s_bresp = 2'b00;
    logic [31:0] s_rdata = '0, s_rdata_val = '0;
    int          n_b_beats = 0, n_r_beats = 0;
    logic        sl_aw_hs, sl_w_hs;

    assign axi_bus.awready = s_aw_en && (s_aw_cnt >= s_aw_dly);
    assign axi_bus.wready  = s_w_en && (s_w_cnt >= s_w_dly);
    assign axi_bus.arready = 1'b1;
    assign axi_bus.bvalid  = s_bvalid;
    assign axi_bus.bresp   = s_bresp;
    assign axi_bus.rvalid  = s_rvalid;
    assign axi_bus.rdata   = s_rdata;
    assign axi_bus.rresp   = 2'b00;

    always @(posedge clk) begin
        sl_aw_hs = axi_bus.awvalid && axi_bus.awready;
        sl_w_hs  = axi_bus.wvalid && axi_bus.wready;
        s_aw_cnt <= (!axi_bus.awvalid || sl_aw_hs) ? 0 : s_aw_cnt + 1;
        s_w_cnt  <= (!axi_bus.wvalid || sl_w_hs) ? 0 : s_w_cnt + 1;
        if (s_bvalid && axi_bus.bready) begin
            s_bvalid  <= 1'b0;
            n_b_beats <= n_b_beats + 1;
        end
        if ((s_aw_seen || sl_aw_hs) && (s_w_seen || sl_w_hs)) begin
            s_bvalid  <= 1'b1;
            s_aw_seen <= 1'b0;
            s_w_seen  <= 1'b0;
        end else begin
            s_aw_seen <= s_aw_seen || sl_aw_hs;
            s_w_seen  <= s_w_seen || sl_w_hs;
        end
        if (s_rvalid && axi_bus.rready) begin
            s_rvalid  <= 1'b0;
            n_r_beats <= n_r_beats + 1;
        end
        if (axi_bus.arvalid && axi_bus.arready) begin
            s_rdata <= s_rdata_val;
            if (s_r_dly == 0) begin
                s_rvalid <= 1'b1;
            end else begin
                s_r_pend <= 1'b1;
                s_r_cnt  <= s_r_dly - 1;
            end
        end else if (s_r_pend) begin
            if (s_r_cnt == 0) begin
                s_rvalid <= 1'b1;
                s_r_pend <= 1'b0;
            end else begin
                s_r_cnt <= s_r_cnt - 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int idx, input logic w, input logic [31:0] a, input logic [31:0] d);
        we[idx]              = w;
        addr[idx*32 +: 32]   = a;
        wdata[idx*32 +: 32]  = d;
        wstrb[idx*4 +: 4]    = 4'hF;
        req[idx]             = 1'b1;
    endtask

    // lat = number of clock edges from the calling cycle to the ack cycle.
    task automatic wait_ack(input string tag, output logic [NR-1:0] a, output int lat);
        lat = 0;
        a   = '0;
        while (a == '0 && lat < 64) begin
            tick();
            lat++;
            a = ack;
        end
        chk({tag, "_ack_seen"}, 64'(a != '0), 64'(1));
    endtask

    int rr_exp2[4] = '{0, 1, 0, 1};
    int rr_exp3[3] = '{2, 0, 1};

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [NR-1:0] a;
        int            lat;
        int            nb0, nr0;
        logic          saw_ack;

        // Reset state
        tick(); tick();
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_ack", 64'(ack), 64'(0));
        chk("rst_rdata", 64'(rdata), 64'(0));
        chk("rst_resp", 64'(resp), 64'(0));
        chk("rst_timeout", 64'(timeout), 64'(0));
        chk("rst_gid", 64'(grant_id), 64'(0));
        chk("rst_valids", 64'({axi_bus.awvalid, axi_bus.wvalid, axi_bus.arvalid}), 64'(0));
        chk("rst_readies", 64'({axi_bus.bready, axi_bus.rready}), 64'(0));
        rst_n = 1'b1;
        #1;
        chk("post_rst_readies", 64'({axi_bus.bready, axi_bus.rready}), 64'(3));
        tick();

        // Two requesters held high: alternate 0,1,0,1 from reset pointer
        drive(0, 1'b1, 32'h0000_0010, 32'h1111_1111);
        drive(1, 1'b1, 32'h0000_0020, 32'h2222_2222);
        for (int i = 0; i < 4; i++) begin
            wait_ack("rr2", a, lat);
            chk("rr2_ack", 64'(a), 64'(1 << rr_exp2[i]));
            chk("rr2_gid", 64'(grant_id), 64'(rr_exp2[i]));
        end
        req = '0;
        tick();

        // All three high: pointer sits at 2 after granting 1
        drive(0, 1'b1, 32'h0000_0010, 32'h1111_1111);
        drive(1, 1'b1, 32'h0000_0020, 32'h2222_2222);
        drive(2, 1'b1, 32'h0000_0030, 32'h3333_3333);
        for (int i = 0; i < 3; i++) begin
            wait_ack("rr3", a, lat);
            chk("rr3_ack", 64'(a), 64'(1 << rr_exp3[i]));
        end
        req = '0;
        tick();

        // Single zero-wait write: AW/W in cycle 1, ack in cycle 3
        drive(0, 1'b1, 32'h0000_1004, 32'hA5A5_5A5A);
        tick();
        chk("wr_awvalid", 64'(axi_bus.awvalid), 64'(1));
        chk("wr_wvalid", 64'(axi_bus.wvalid), 64'(1));
        chk("wr_awaddr", 64'(axi_bus.awaddr), 64'h1004);
        chk("wr_wdata", 64'(axi_bus.wdata), 64'hA5A5_5A5A);
        chk("wr_wstrb", 64'(axi_bus.wstrb), 64'hF);
        chk("wr_awprot", 64'(axi_bus.awprot), 64'(0));
        chk("wr_busy", 64'(busy), 64'(1));
        tick();
        chk("wr_c2_ack", 64'(ack), 64'(0));
        tick();
        chk("wr_c3_ack", 64'(ack), 64'b001);
        chk("wr_resp", 64'(resp), 64'(0));
        chk("wr_rdata_kept", 64'(rdata), 64'(0));
        req = '0;
        tick();

        // Read with 5 extra cycles before rvalid
        s_r_dly = 5;
        s_rdata_val = 32'h0000_0001;
        drive(1, 1'b0, 32'h0000_1000, 32'h0);
        tick();
        chk("rd_arvalid", 64'(axi_bus.arvalid), 64'(1));
        chk("rd_araddr", 64'(axi_bus.araddr), 64'h1000);
        chk("rd_arprot", 64'(axi_bus.arprot), 64'(0));
        chk("rd_gid", 64'(grant_id), 64'(1));
        wait_ack("rd", a, lat);
        chk("rd_lat", 64'(lat), 64'(7));
        chk("rd_ackbit", 64'(a), 64'b010);
        chk("rd_rdata", 64'(rdata), 64'h1);
        chk("rd_resp", 64'(resp), 64'(0));
        req = '0;
        tick();

        // Write returning SLVERR: rdata must keep the last read value
        s_r_dly = 0;
        s_bresp = 2'b10;
        drive(2, 1'b1, 32'h0000_2000, 32'hCAFE_F00D);
        wait_ack("wr_err", a, lat);
        chk("wr_err_lat", 64'(lat), 64'(3));
        chk("wr_err_ack", 64'(a), 64'b100);
        chk("wr_err_resp", 64'(resp), 64'b10);
        chk("wr_err_rdata", 64'(rdata), 64'h1);
        req = '0;
        s_bresp = 2'b00;
        tick();

        // awready two cycles ahead of wready
        s_aw_dly = 1;
        s_w_dly  = 3;
        nb0 = n_b_beats;
        drive(0, 1'b1, 32'h0000_1008, 32'h0BAD_BEEF);
        tick();
        tick();
        chk("skew_c2", 64'({axi_bus.awvalid, axi_bus.wvalid}), 64'b11);
        tick();
        chk("skew_c3", 64'({axi_bus.awvalid, axi_bus.wvalid}), 64'b01);
        tick();
        chk("skew_c4", 64'({axi_bus.awvalid, axi_bus.wvalid}), 64'b01);
        tick();
        chk("skew_c5", 64'({axi_bus.awvalid, axi_bus.wvalid, ack != '0}), 64'b000);
        tick();
        chk("skew_c6_ack", 64'(ack), 64'b001);
        req = '0;
        s_aw_dly = 0;
        s_w_dly  = 0;
        tick(); tick();
        chk("skew_b_beats", 64'(n_b_beats - nb0), 64'(1));

        // Slave never ready: timeout after 16 transaction cycles
        s_aw_en = 1'b0;
        s_w_en  = 1'b0;
        drive(0, 1'b1, 32'h0000_100C, 32'h5555_AAAA);
        wait_ack("tmo", a, lat);
        chk("tmo_lat", 64'(lat), 64'(17));
        chk("tmo_ack", 64'(a), 64'b001);
        chk("tmo_pulse", 64'(timeout), 64'(1));
        chk("tmo_resp", 64'(resp), 64'b10);
        chk("tmo_valids", 64'({axi_bus.awvalid, axi_bus.wvalid}), 64'b00);
        req = '0;
        tick();
        chk("tmo_pulse_end", 64'({timeout, busy}), 64'b00);
        s_aw_en = 1'b1;
        s_w_en  = 1'b1;
        tick();

        // Reset while waiting for read data
        s_r_dly = 10;
        s_rdata_val = 32'h1234_5678;
        nr0 = n_r_beats;
        drive(1, 1'b0, 32'h0000_1000, 32'h0);
        tick(); tick(); tick();
        chk("mid_busy", 64'(busy), 64'(1));
        rst_n = 1'b0;
        req = '0;
        #1;
        chk("mid_rst_busy", 64'(busy), 64'(0));
        chk("mid_rst_ack", 64'(ack), 64'(0));
        chk("mid_rst_rdata", 64'(rdata), 64'(0));
        chk("mid_rst_resp", 64'(resp), 64'(0));
        chk("mid_rst_gid", 64'(grant_id), 64'(0));
        chk("mid_rst_axi", 64'({axi_bus.arvalid, axi_bus.bready, axi_bus.rready}), 64'(0));
        tick(); tick();
        rst_n = 1'b1;
        #1;
        chk("mid_rel_rready", 64'(axi_bus.rready), 64'(1));
        saw_ack = 1'b0;
        for (int i = 0; i < 14; i++) begin
            tick();
            if (ack != '0) saw_ack = 1'b1;
        end
        chk("mid_no_ack", 64'(saw_ack), 64'(0));
        chk("mid_stray_drained", 64'(n_r_beats - nr0), 64'(1));
        chk("mid_stray_hidden", 64'(rdata), 64'(0));

        // Next request after reset is serviced normally
        s_r_dly = 0;
        s_rdata_val = 32'hDEAD_BEEF;
        drive(0, 1'b0, 32'h0000_2000, 32'h0);
        wait_ack("post", a, lat);
        chk("post_lat", 64'(lat), 64'(3));
        chk("post_ack", 64'(a), 64'b001);
        chk("post_rdata", 64'(rdata), 64'hDEAD_BEEF);
        chk("post_resp", 64'(resp), 64'(0));
        req = '0;
        tick();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
